// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
// Config addresses beyond the channel compares are offsets from NUM_CHANNELS.
package pwm_pkg;

  localparam int ADDR_TOP_OFS      = 0;
  localparam int ADDR_PRESCALE_OFS = 1;
  localparam int ADDR_COMMIT_OFS   = 2;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } align_mode_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Valid/ready configuration write port for pwm_multi.
// The register front-end is the master; the PWM block is the slave.
interface pwm_multi_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus shared period counter (edge-aligned up or center-aligned up/down).
// Exposes the next counter value so the channel comparators can register their outputs.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int          RESOLUTION = 8,
  parameter int          PRESCALE_W = 8,
  parameter align_mode_e MODE       = EDGE
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [RESOLUTION-1:0] i_top,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [RESOLUTION-1:0] o_counter_next,
  output logic                  o_tick,
  output logic                  o_boundary
);

  logic [RESOLUTION-1:0] counter;
  logic                  count_up;
  logic                  up_next;
  logic [PRESCALE_W-1:0] ps_count;

  assign o_tick = i_enable && (ps_count == i_prescale);

  always_comb begin
    o_counter_next = counter;
    up_next        = count_up;
    if (!i_enable) begin
      o_counter_next = '0;
      up_next        = 1'b1;
    end else if (o_tick) begin
      if (MODE == EDGE) begin
        o_counter_next = (counter >= i_top) ? '0 : counter + RESOLUTION'(1);
      end else if (count_up && (counter < i_top)) begin
        o_counter_next = counter + RESOLUTION'(1);
      end else begin
        // Turning at top or descending; reaching zero flips back to counting up.
        o_counter_next = (counter == '0) ? '0 : counter - RESOLUTION'(1);
        up_next        = (o_counter_next == '0);
      end
    end
  end

  assign o_boundary = o_tick && (o_counter_next == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      counter  <= '0;
      count_up <= 1'b1;
      ps_count <= '0;
    end else begin
      counter  <= o_counter_next;
      count_up <= up_next;
      if (!i_enable || o_tick) begin
        ps_count <= '0;
      end else begin
        ps_count <= ps_count + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with double-buffered compare/top/prescale registers.
// Shadow values move to the active set together at a period boundary after a commit.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int RESOLUTION     = 8,
  parameter int NUM_CHANNELS   = 4,
  parameter int PRESCALE_W     = 8,
  parameter int CENTER_ALIGNED = 0,
  parameter int ADDR_W         = $clog2(NUM_CHANNELS + 3)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  pwm_multi_if.slave              cfg,
  output logic [NUM_CHANNELS-1:0] o_pwm,
  output logic                    o_period_start
);

  localparam align_mode_e       MODE        = (CENTER_ALIGNED != 0) ? CENTER : EDGE;
  localparam logic [ADDR_W-1:0] ADDR_TOP    = ADDR_W'(NUM_CHANNELS + ADDR_TOP_OFS);
  localparam logic [ADDR_W-1:0] ADDR_PRE    = ADDR_W'(NUM_CHANNELS + ADDR_PRESCALE_OFS);
  localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'(NUM_CHANNELS + ADDR_COMMIT_OFS);

  logic                  accept;
  logic                  apply;
  logic                  armed;
  logic                  tick;
  logic                  boundary;
  logic [RESOLUTION-1:0] counter_next;
  logic [RESOLUTION-1:0] top_shadow;
  logic [RESOLUTION-1:0] top_active;
  logic [PRESCALE_W-1:0] pre_shadow;
  logic [PRESCALE_W-1:0] pre_active;

  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.cfg_ready = ~armed;
  // A parked counter has no boundary to wait for, so a pending commit lands at once.
  assign apply         = armed && (boundary || !i_enable);

  pwm_timebase #(
    .RESOLUTION (RESOLUTION),
    .PRESCALE_W (PRESCALE_W),
    .MODE       (MODE)
  ) u_timebase (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_top          (top_active),
    .i_prescale     (pre_active),
    .o_counter_next (counter_next),
    .o_tick         (tick),
    .o_boundary     (boundary)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      armed          <= 1'b0;
      top_shadow     <= '1;
      top_active     <= '1;
      pre_shadow     <= '0;
      pre_active     <= '0;
      o_period_start <= 1'b0;
    end else begin
      armed          <= (armed && !apply) || (accept && (cfg.cfg_addr == ADDR_COMMIT));
      o_period_start <= tick && boundary;
      if (apply) begin
        top_active <= top_shadow;
        pre_active <= pre_shadow;
      end
      if (accept && (cfg.cfg_addr == ADDR_TOP)) begin
        top_shadow <= cfg.cfg_data[RESOLUTION-1:0];
      end
      if (accept && (cfg.cfg_addr == ADDR_PRE)) begin
        pre_shadow <= cfg.cfg_data[PRESCALE_W-1:0];
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    localparam logic [ADDR_W-1:0] CH_ADDR = ADDR_W'(c);

    logic [RESOLUTION-1:0] cmp_shadow;
    logic [RESOLUTION-1:0] cmp_active;
    logic [RESOLUTION-1:0] cmp_next;
    logic                  pwm_q;

    // The first cycle of a new period already compares against the freshly applied value.
    assign cmp_next = apply ? cmp_shadow : cmp_active;
    assign o_pwm[c] = pwm_q;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        cmp_shadow <= '0;
        cmp_active <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (accept && (cfg.cfg_addr == CH_ADDR)) begin
          cmp_shadow <= cfg.cfg_data[RESOLUTION-1:0];
        end
        cmp_active <= cmp_next;
        pwm_q      <= i_enable && (counter_next < cmp_next);
      end
    end
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator.
- NUM_CHANNELS outputs share one period counter, with a programmable period, a clock prescaler and edge- or center-aligned counting.
- Per-channel duty values are double-buffered. New values are written through a valid/ready config port and take effect together at a period boundary after a commit, so outputs never glitch.
- Sits between a register/command front-end and LED/motor/audio pins.

Parameters:
- RESOLUTION, 8, counter/compare/top width in bits.
- NUM_CHANNELS, 4, number of PWM outputs (1..16).
- PRESCALE_W, 8, prescaler divisor width.
- CENTER_ALIGNED, 0, 0 = edge-aligned up-counter; 1 = up/down counter.
- ADDR_W, $clog2(NUM_CHANNELS+3), config address width (derived; do not override).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_enable  in  1  run counter; low = hold in idle.
- i_cfg_valid  in  1  config write request.
- o_cfg_ready  out  1  config write accepted when valid && ready.
- i_cfg_addr  in  ADDR_W  target of the write:
  - 0..NUM_CHANNELS-1: channel compare.
  - NUM_CHANNELS: period top.
  - NUM_CHANNELS+1: prescale divisor.
  - NUM_CHANNELS+2: commit.
- i_cfg_data  in  max(RESOLUTION,PRESCALE_W)  write data; low bits used; ignored for commit.
- o_pwm  out  NUM_CHANNELS  PWM outputs, registered.
- o_period_start  out  1  one-cycle pulse at each period boundary.

Behaviour:
- **Reset** (i_reset high at a clock edge):
  - counter=0, direction=up, prescale count=0.
  - All shadow and active compares = 0; shadow/active top = 2^RESOLUTION-1; shadow/active prescale = 0.
  - armed=0, o_pwm=0, o_period_start=0, o_cfg_ready=1.
  - Reset mid-operation discards any pending or armed update.
- **Config writes:**
  - Accepted only on valid && ready.
  - Writes to compare/top/prescale addresses update shadow registers only.
  - A write to the commit address sets armed=1; o_cfg_ready drops the next cycle and stays low while armed=1.
  - Writes to addresses above NUM_CHANNELS+2 are accepted and ignored.
- **Tick:**
  - Asserted when the prescale count equals the active prescale value, then the count clears; otherwise the count increments.
  - Divisor d gives one tick per d+1 clocks. Prescale count only runs while enabled.
- **Edge-aligned counting:**
  - On each tick, counter = (counter==top) ? 0 : counter+1.
  - Period = (top+1) ticks.
- **Center-aligned counting:**
  - Counts up to top, flips direction, counts down to 0, flips to up.
  - Each value is visited once per turn; period = 2*top ticks.
  - top=0 degenerates to a constant counter 0, with a boundary every tick.
- **Boundary event:** the tick on which the counter becomes 0.
  - o_period_start pulses in the same cycle the counter register shows 0.
  - If armed, all shadow values (every compare, top, prescale) copy to active on that same edge, and armed clears.
  - o_cfg_ready returns high the following cycle.
- **Outputs:**
  - o_pwm[c] <= (counter_next < active_compare[c]); registered, valid the same cycle the counter shows that value.
  - compare=0 → constant low; compare > top → constant high (100%).
- **i_enable low:**
  - Counter and direction held at 0/up, prescale count 0, o_pwm=0, o_period_start=0.
  - Writes are still accepted. An armed commit applies on the next clock (boundary treated as immediate).
- **Simultaneous events:**
  - A commit accepted in the same cycle as a boundary takes effect at the next boundary, not this one.
  - A shadow write in the boundary cycle after commit cannot occur, because ready is low.
- **Width rule:** all counter/compare arithmetic is in RESOLUTION bits; top < 2^RESOLUTION, so the counter never overflows.

Decomposition:
- Package pwm_pkg holds:
  - address offset constants ADDR_TOP_OFS=0, ADDR_PRESCALE_OFS=1, ADDR_COMMIT_OFS=2 (added to NUM_CHANNELS);
  - an align-mode enum (EDGE, CENTER).
- One sub-module, pwm_timebase: prescaler plus up / up-down counter. It outputs counter_next, tick and a boundary flag.
- Top level holds the shadow/active registers, the commit handshake and the per-channel comparators (generate loop).

Test Plan:
1. RESOLUTION=8, NUM_CHANNELS=4; write top=9, ch0=3, commit, enable → o_pwm[0] high 3 of every 10 clocks; o_period_start every 10 clocks; other channels low.
2. top=9; ch1=0, ch2=10, ch3=9, commit → ch1 always low, ch2 always high, ch3 high 9 of 10.
3. Running ch0=3; at counter=4 write ch0=7 then commit → ready low until the next boundary; current period still 3 high; next period 7 high; ready high one cycle after the boundary.
4. CENTER_ALIGNED=1, top=4, ch0=2 → counter sequence 0,1,2,3,4,3,2,1 repeating; o_pwm[0] high 3 of 8 clocks; o_period_start every 8 clocks.
5. Prescale=2, top=3, ch0=1 → counter advances every 3 clocks; period 12 clocks; o_pwm[0] high 3 clocks.
6. Armed commit pending, assert i_reset for one cycle mid-period → o_pwm=0, o_cfg_ready=1, old shadow discarded; after re-enable all outputs stay low (compares 0) and period = 256 clocks.
